mem_initiator: RTL and testbench
================================

# mem_initiator

Bus initiator for the MU0 memory interface: accepts single read/write requests from the CPU control path over a valid/ready handshake. It drives `memRq`, `readNotWrite`, `addr` and `dataIn` into the memory block with a glitch-free sequence, and captures `dataOut` on reads. It returns one response per request over a second valid/ready handshake. It sits between the MU0 control FSM and the `memory` block, whose ports it wires to directly.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `WAIT_CYCLES`, 1, cycles `memRq` is held asserted per access; 0 is treated as 1

- `clk`  in  1  clock; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `reqValid`  in  1  request present
- `reqReady`  out  1  initiator can accept a request
- `reqRead`  in  1  1 = read, 0 = write
- `reqAddr`  in  ADDR_W  request address
- `reqWdata`  in  DATA_W  write data
- `rspValid`  out  1  response present
- `rspReady`  in  1  consumer takes the response
- `rspRdata`  out  DATA_W  read data; 0 for write responses
- `rspWrite`  out  1  1 if the response completes a write
- `txnCount`  out  16  completed transactions, wraps at 0xFFFF→0
- `memRq`  out  1  memory request to the memory block
- `readNotWrite`  out  1  memory direction: 1 = read
- `addr`  out  ADDR_W  memory address
- `dataIn`  out  DATA_W  write data to the memory block
- `dataOut`  in  DATA_W  read data from the memory block; 0x00FF while `memRq`=0

## Operation
- Moore FSM with states IDLE, SETUP, ACCESS, HOLD, RESP. All outputs are registered or decoded from the state register only.
- IDLE: `reqReady`=1, `memRq`=0, `readNotWrite`=1.
  - On `reqValid`&&`reqReady`, latch `reqRead`, `reqAddr` and `reqWdata` and go to SETUP.
- SETUP (1 cycle): `addr` and `dataIn` are driven from the latched request. `memRq`=0 and `readNotWrite`=1. Go to ACCESS.
- ACCESS (`WAIT_CYCLES` cycles): `memRq`=1 and `readNotWrite`=latched `reqRead`.
  - A down-counter is loaded with `WAIT_CYCLES-1` on entry.
  - On the edge leaving ACCESS, a read captures `dataOut` into `rspRdata`; a write loads 0.
  - Go to HOLD.
- HOLD (1 cycle): `memRq`=0 and `readNotWrite`=1, while `addr` and `dataIn` are still held. Go to RESP.
- RESP: `rspValid`=1, and `rspRdata` and `rspWrite` are stable.
  - On `rspReady`, go to IDLE and increment `txnCount`.
- `readNotWrite` is 0 only while `memRq`=1, so no write is ever open outside ACCESS.
- `addr` and `dataIn` never change while `memRq`=1, or in the cycles just before and after it.
- `addr` and `dataIn` keep their last values while in IDLE.
- `reqReady` is 0 in every state except IDLE, so requests are never accepted in RESP.

## Timing
- Reset values: state=IDLE, `reqReady`=1, `rspValid`=0, `rspRdata`=0, `rspWrite`=0, `txnCount`=0, `memRq`=0, `readNotWrite`=1, `addr`=0, `dataIn`=0.
- Accept edge E0:
  - SETUP after E0.
  - `memRq` rises after E1 and falls after E(1+`WAIT_CYCLES`).
  - `rspValid` rises after E(2+`WAIT_CYCLES`), i.e. 3 cycles after accept when `WAIT_CYCLES`=1.
- Read data is sampled on the last ACCESS edge; `dataOut` must be valid `WAIT_CYCLES` cycles after `memRq` rises.
- Backpressure: RESP holds indefinitely while `rspReady`=0, with outputs unchanged.
- Minimum request-to-request spacing is `WAIT_CYCLES`+4 cycles. `rspReady` is already high in RESP in the best case.
- Reset mid-operation, in any state: the next edge forces the reset values. `memRq` drops immediately, the pending response is discarded, and `txnCount` is not incremented.
- `reqValid` asserted outside IDLE is ignored. The requester must hold it and its payload until `reqReady`.

## Test plan
- Reset then idle 5 cycles -> `memRq`=0, `readNotWrite`=1, `reqReady`=1, `rspValid`=0, `txnCount`=0.
- Write 0x00AA to 0x0000, then read 0x0000 (`WAIT_CYCLES`=1, `rspReady`=1) -> write response has `rspWrite`=1 and `rspRdata`=0; read response has `rspRdata`=0x00AA; `txnCount`=2; `rspValid` 3 cycles after each accept.
- Write 0x0055 to 0x001F, then read 0x001F -> `rspRdata`=0x0055. Check that `readNotWrite`=0 only during the single `memRq` cycle and that `addr` is stable from SETUP through HOLD.
- Read 0x001F with `rspReady`=0 for 5 cycles -> `rspValid` held, `rspRdata`=0x0055 stable, `reqReady`=0 and `reqValid` ignored; `txnCount` increments only on the `rspReady` cycle.
- `WAIT_CYCLES`=3, read 0x0000 -> `memRq` high exactly 3 cycles; `rspValid` 5 cycles after accept.
- `rst`=1 during ACCESS of a write -> `memRq`=0 and `readNotWrite`=1 after the next edge, no response, `txnCount` unchanged, `reqReady`=1 once `rst` deasserts.

Source files
------------

// File: rtl/mem_initiator_if.sv
// Request/response handshake plus MU0 memory-block wires for mem_initiator.
interface mem_initiator_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              reqValid;
  logic              reqReady;
  logic              reqRead;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              rspValid;
  logic              rspReady;
  logic [DATA_W-1:0] rspRdata;
  logic              rspWrite;
  logic [15:0]       txnCount;
  logic              memRq;
  logic              readNotWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;

  modport master (
    input  reqValid, reqRead, reqAddr, reqWdata, rspReady, dataOut,
    output reqReady, rspValid, rspRdata, rspWrite, txnCount,
           memRq, readNotWrite, addr, dataIn
  );

  modport slave (
    output reqValid, reqRead, reqAddr, reqWdata, rspReady, dataOut,
    input  reqReady, rspValid, rspRdata, rspWrite, txnCount,
           memRq, readNotWrite, addr, dataIn
  );
endinterface

// File: rtl/mem_initiator.sv
// MU0 memory initiator: one access per request, response WAIT_CYCLES+2 cycles after accept.
// Holds the response indefinitely under rspReady=0; reqReady is high only when idle.
module mem_initiator #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_initiator_if.master bus
);
  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = $clog2(WC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

  state_t        state;
  logic          rd_q;
  logic [CW-1:0] cnt;

  // All bus-facing outputs are registers updated alongside the state,
  // so memRq/readNotWrite change only on clean clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rd_q              <= 1'b1;
      cnt               <= '0;
      bus.reqReady      <= 1'b1;
      bus.rspValid      <= 1'b0;
      bus.rspRdata      <= {DATA_W{1'b0}};
      bus.rspWrite      <= 1'b0;
      bus.txnCount      <= 16'h0000;
      bus.memRq         <= 1'b0;
      bus.readNotWrite  <= 1'b1;
      bus.addr          <= {ADDR_W{1'b0}};
      bus.dataIn        <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid && bus.reqReady) begin
            rd_q         <= bus.reqRead;
            bus.addr     <= bus.reqAddr;
            bus.dataIn   <= bus.reqWdata;
            bus.reqReady <= 1'b0;
            state        <= SETUP;
          end
        end
        SETUP: begin
          bus.memRq        <= 1'b1;
          bus.readNotWrite <= rd_q;
          cnt              <= CW'(WC - 1);
          state            <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) begin
            bus.memRq        <= 1'b0;
            bus.readNotWrite <= 1'b1;
            bus.rspRdata     <= rd_q ? bus.dataOut : {DATA_W{1'b0}};
            bus.rspWrite     <= ~rd_q;
            state            <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          bus.rspValid <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rspReady) begin
            bus.rspValid <= 1'b0;
            bus.reqReady <= 1'b1;
            bus.txnCount <= bus.txnCount + 16'h0001;
            state        <= IDLE;
          end
        end
        default: begin
          bus.memRq        <= 1'b0;
          bus.readNotWrite <= 1'b1;
          bus.rspValid     <= 1'b0;
          bus.reqReady     <= 1'b1;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator: two instances (WAIT_CYCLES 1 and 3) against a memory array model.
module tb_mem_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_initiator_if i1 ();
  mem_initiator_if i3 ();

  mem_initiator #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(i1.master));
  mem_initiator #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(i3.master));

  bit          sel;
  logic        req_valid, req_read, rsp_ready;
  logic [15:0] req_addr, req_wdata;

  assign i1.reqValid = req_valid & ~sel;
  assign i3.reqValid = req_valid & sel;
  assign i1.reqRead  = req_read;
  assign i3.reqRead  = req_read;
  assign i1.reqAddr  = req_addr;
  assign i3.reqAddr  = req_addr;
  assign i1.reqWdata = req_wdata;
  assign i3.reqWdata = req_wdata;
  assign i1.rspReady = rsp_ready;
  assign i3.rspReady = rsp_ready;

  // Memory block stand-ins
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  bit          init_mem = 1'b1;
  assign i1.dataOut = i1.memRq ? mem1[i1.addr[7:0]] : 16'h00FF;
  assign i3.dataOut = i3.memRq ? mem3[i3.addr[7:0]] : 16'h00FF;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 16'h1000 + 16'(i);
        mem3[i] <= 16'h3000 + 16'(i);
      end
    end else begin
      if (i1.memRq && !i1.readNotWrite) mem1[i1.addr[7:0]] <= i1.dataIn;
      if (i3.memRq && !i3.readNotWrite) mem3[i3.addr[7:0]] <= i3.dataIn;
    end
  end

  logic        o_memRq, o_rnw, o_reqReady, o_rspValid, o_rspWrite;
  logic [15:0] o_addr, o_din, o_rdata, o_txn;
  assign o_memRq    = sel ? i3.memRq        : i1.memRq;
  assign o_rnw      = sel ? i3.readNotWrite : i1.readNotWrite;
  assign o_reqReady = sel ? i3.reqReady     : i1.reqReady;
  assign o_rspValid = sel ? i3.rspValid     : i1.rspValid;
  assign o_rspWrite = sel ? i3.rspWrite     : i1.rspWrite;
  assign o_addr     = sel ? i3.addr         : i1.addr;
  assign o_din      = sel ? i3.dataIn       : i1.dataIn;
  assign o_rdata    = sel ? i3.rspRdata     : i1.rspRdata;
  assign o_txn      = sel ? i3.txnCount     : i1.txnCount;

  // Reference: expected memory contents and completed-transaction counts
  logic [15:0] rmem [2][256];
  int          exp_txn [2];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  task automatic txn(input bit rd, input logic [15:0] a, input logic [15:0] wd, input int stall);
    int          w;
    int          t;
    logic [15:0] exp_rd;
    w      = sel ? 3 : 1;
    exp_rd = rd ? rmem[sel][a[7:0]] : 16'h0000;
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_addr = a; req_wdata = wd;
    rsp_ready = (stall == 0);
    t = 0;
    while (!o_reqReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", o_reqReady, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd;
    for (int k = 0; k <= w + 2; k++) begin
      @(negedge clk);
      chk("memRq",        o_memRq,    (k >= 1 && k <= w));
      chk("readNotWrite", o_rnw,      !(k >= 1 && k <= w && !rd));
      chk("addr_held",    o_addr,     a);
      chk("dataIn_held",  o_din,      wd);
      chk("reqReady_busy", o_reqReady, 0);
      chk("rspValid_time", o_rspValid, (k == w + 2));
    end
    chk("rspRdata", o_rdata, exp_rd);
    chk("rspWrite", o_rspWrite, !rd);
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1; req_addr = a ^ 16'h0040;
      @(negedge clk);
      chk("stall_rspValid", o_rspValid, 1);
      chk("stall_rdata",    o_rdata, exp_rd);
      chk("stall_reqReady", o_reqReady, 0);
      chk("stall_txnCount", o_txn, 16'(exp_txn[sel]));
      chk("stall_addr",     o_addr, a);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    exp_txn[sel]++;
    chk("done_rspValid", o_rspValid, 0);
    chk("done_reqReady", o_reqReady, 1);
    chk("txnCount",      o_txn, 16'(exp_txn[sel]));
    chk("idle_addr",     o_addr, a);
    if (!rd) rmem[sel][a[7:0]] = wd;
  endtask

  initial begin
    req_valid = 1'b0; req_read = 1'b1; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; sel = 1'b0;
    exp_txn[0] = 0; exp_txn[1] = 0;
    for (int i = 0; i < 256; i++) begin
      rmem[0][i] = 16'h1000 + 16'(i);
      rmem[1][i] = 16'h3000 + 16'(i);
    end
    repeat (3) @(posedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_memRq",    o_memRq, 0);
      chk("rst_rnw",      o_rnw, 1);
      chk("rst_reqReady", o_reqReady, 1);
      chk("rst_rspValid", o_rspValid, 0);
      chk("rst_txnCount", o_txn, 0);
      chk("rst_addr",     o_addr, 0);
      chk("rst_rdata",    o_rdata, 0);
    end

    // Reset in the middle of a write access
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_addr = 16'h00F0; req_wdata = 16'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_memRq_before", o_memRq, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_memRq",    o_memRq, 0);
    chk("midrst_rnw",      o_rnw, 1);
    chk("midrst_rspValid", o_rspValid, 0);
    chk("midrst_txnCount", o_txn, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_rsp", o_rspValid, 0);
      chk("midrst_quiet",  o_memRq, 0);
    end
    chk("midrst_reqReady", o_reqReady, 1);
    chk("midrst_txn_after", o_txn, 0);

    // Directed transactions on the WAIT_CYCLES=1 instance
    txn(1'b0, 16'h0000, 16'h00AA, 0);
    txn(1'b1, 16'h0000, 16'h1234, 0);
    txn(1'b0, 16'h001F, 16'h0055, 0);
    txn(1'b1, 16'h001F, 16'h0000, 0);
    txn(1'b1, 16'h001F, 16'h0000, 5);

    // WAIT_CYCLES=3 instance
    sel = 1'b1;
    txn(1'b1, 16'h0000, 16'h0000, 0);

    for (int n = 0; n < 30; n++) begin
      sel = 1'($urandom_range(0, 1));
      txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
